// File: rtl/oscill_nios_niosii_cpu_debug_mon_access_if.sv
// CPU-side bus of the debug monitor RAM: Avalon-style single-port access with waitrequest.
// The CPU (master) drives address/commands; the monitor (slave) returns read data and stall.
interface oscill_nios_niosii_cpu_debug_mon_access_if;
  logic [7:0]  ram_address;
  logic        ram_read;
  logic        ram_write;
  logic [31:0] ram_writedata;
  logic [3:0]  ram_byteenable;
  logic        debugaccess;
  logic [31:0] ram_readdata;
  logic        ram_waitrequest;

  modport master (
    output ram_address, ram_read, ram_write, ram_writedata, ram_byteenable, debugaccess,
    input  ram_readdata, ram_waitrequest
  );

  modport slave (
    input  ram_address, ram_read, ram_write, ram_writedata, ram_byteenable, debugaccess,
    output ram_readdata, ram_waitrequest
  );
endinterface

// File: rtl/oscill_nios_niosii_cpu_debug_mon_access.sv
// Debug monitor RAM shared between JTAG (take_* strobes) and the CPU bus; JTAG has priority.
// Optional macro DEBUG_MON_WRITE_PROTECT_EN: CPU writes need debugaccess=1 to take effect.
module oscill_nios_niosii_cpu_debug_mon_access (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_no_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        monitor_error,
  oscill_nios_niosii_cpu_debug_mon_access_if.slave cpu
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;

  logic [31:0] mem [0:255];
  logic [31:0] rd_q;

  logic [7:0]  jtag_addr;
  logic [7:0]  pend_addr;
  logic [31:0] pend_data;
  logic        pend_wr;

  logic        any_take;
  logic        accept;
  logic        accept_b;
  logic        accept_a;
  logic        accept_n;

  logic        wait_req;
  logic        cpu_rd;
  logic        cpu_wr;
  logic        cpu_rd_d;
  logic [31:0] cpu_hold;

  logic        port_rd;
  logic        port_wr;
  logic [7:0]  port_addr;
  logic [31:0] port_wdata;
  logic [3:0]  port_be;

  logic        unused_jdo;
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  // Strobes only count when the FSM is idle; ocimem_b outranks ocimem_a outranks no_action.
  always_comb begin
    any_take = take_action_ocimem_b | take_action_ocimem_a | take_no_action_ocimem_a;
    accept   = any_take && (state == IDLE);
    accept_b = accept && take_action_ocimem_b;
    accept_a = accept && !take_action_ocimem_b && take_action_ocimem_a;
    accept_n = accept && !take_action_ocimem_b && !take_action_ocimem_a && take_no_action_ocimem_a;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // An address-only load (jdo[34]=0) needs no RAM cycle, so the FSM stays idle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept_b || accept_n || (accept_a && jdo[34])) begin
          next_state = ACCESS;
        end
      end
      ACCESS:  next_state = pend_wr ? IDLE : CAPTURE;
      CAPTURE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    monitor_ready = (state == IDLE);
    wait_req      = any_take || (state != IDLE);
    cpu_rd        = cpu.ram_read && !cpu.ram_write && !wait_req;
`ifdef DEBUG_MON_WRITE_PROTECT_EN
    cpu_wr        = cpu.ram_write && cpu.debugaccess && !wait_req;
`else
    cpu_wr        = cpu.ram_write && !wait_req;
`endif
    port_addr     = cpu.ram_address;
    port_wdata    = cpu.ram_writedata;
    port_be       = cpu.ram_byteenable;
    port_wr       = cpu_wr;
    port_rd       = cpu_rd;
    if (state == ACCESS) begin
      port_addr  = pend_addr;
      port_wdata = pend_data;
      port_be    = 4'hF;
      port_wr    = pend_wr;
      port_rd    = !pend_wr;
    end
  end

`ifndef DEBUG_MON_WRITE_PROTECT_EN
  logic unused_dbg;
  assign unused_dbg = cpu.debugaccess;
`endif

  assign cpu.ram_waitrequest = wait_req;

  // Shared single port; no reset so contents survive reset_n.
  always_ff @(posedge clk) begin
    if (port_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (port_be[i]) begin
          mem[port_addr][8*i +: 8] <= port_wdata[8*i +: 8];
        end
      end
    end
    if (port_rd) begin
      rd_q <= mem[port_addr];
    end
  end

  // rd_q is shared with JTAG reads, so CPU data is copied aside to stay stable until the next CPU read.
  assign cpu.ram_readdata = cpu_rd_d ? rd_q : cpu_hold;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jtag_addr     <= 8'd0;
      pend_wr       <= 1'b0;
      pend_addr     <= 8'd0;
      pend_data     <= 32'd0;
      MonDReg       <= 32'd0;
      monitor_error <= 1'b0;
      cpu_rd_d      <= 1'b0;
      cpu_hold      <= 32'd0;
    end else begin
      cpu_rd_d <= cpu_rd;
      if (cpu_rd_d) begin
        cpu_hold <= rd_q;
      end

      if (any_take && !accept) begin
        monitor_error <= 1'b1;
      end else if (accept_a) begin
        monitor_error <= 1'b0;
      end

      if (accept_b) begin
        pend_wr   <= 1'b1;
        pend_addr <= jtag_addr;
        pend_data <= jdo[34:3];
        jtag_addr <= jtag_addr + 8'd1;
      end else if (accept_a) begin
        pend_wr   <= 1'b0;
        pend_addr <= jdo[17:10];
        jtag_addr <= jdo[17:10];
      end else if (accept_n) begin
        pend_wr   <= 1'b0;
        pend_addr <= jtag_addr;
        jtag_addr <= jtag_addr + 8'd1;
      end

      if (state == CAPTURE) begin
        MonDReg <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_oscill_nios_niosii_cpu_debug_mon_access.sv
// Self-checking bench for the debug monitor RAM: directed scenarios plus a randomized
// mix of JTAG and CPU accesses, all checked against a word-level memory model.
module tb_oscill_nios_niosii_cpu_debug_mon_access;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic        take_action_ocimem_a = 1'b0;
  logic        take_no_action_ocimem_a = 1'b0;
  logic        take_action_ocimem_b = 1'b0;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  oscill_nios_niosii_cpu_debug_mon_access_if bus ();

  oscill_nios_niosii_cpu_debug_mon_access dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .cpu                     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [256];
  logic [7:0]  model_addr = 8'd0;
  logic        model_err = 1'b0;
  logic [31:0] model_mon = 32'd0;
  logic [31:0] model_cpu_rd = 32'd0;

  initial begin
    bus.ram_address    = 8'd0;
    bus.ram_read       = 1'b0;
    bus.ram_write      = 1'b0;
    bus.ram_writedata  = 32'd0;
    bus.ram_byteenable = 4'd0;
    bus.debugaccess    = 1'b0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  function automatic logic [37:0] jdoAddr(input logic [7:0] a, input logic rd);
    logic [37:0] j;
    j        = '0;
    j[17:10] = a;
    j[34]    = rd;
    return j;
  endfunction

  function automatic logic [37:0] jdoData(input logic [31:0] d);
    logic [37:0] j;
    j       = '0;
    j[34:3] = d;
    return j;
  endfunction

  // Holds the given strobes for one cycle; returns #1 after the edge that sampled them.
  task automatic applyStimulus(input logic b, input logic a, input logic n, input logic [37:0] j);
    take_action_ocimem_b    = b;
    take_action_ocimem_a    = a;
    take_no_action_ocimem_a = n;
    jdo                     = j;
    #1;
    checkOutput("waitreq_on_strobe", bus.ram_waitrequest, 1);
    tick();
    take_action_ocimem_b    = 1'b0;
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    jdo                     = '0;
  endtask

  task automatic jtagAddr(input logic [7:0] a);
    applyStimulus(0, 1, 0, jdoAddr(a, 1'b0));
    model_addr = a;
    model_err  = 1'b0;
    tick();
    tick();
    checkOutput("addr_err_clear", monitor_error, model_err);
    checkOutput("addr_ready", monitor_ready, 1);
  endtask

  task automatic jtagWrite(input logic [31:0] d);
    applyStimulus(1, 0, 0, jdoData(d));
    model_mem[model_addr] = d;
    model_addr            = model_addr + 8'd1;
    checkOutput("wr_busy", monitor_ready, 0);
    tick();
    checkOutput("wr_ready", monitor_ready, 1);
  endtask

  task automatic jtagRead(input logic use_a, input logic [7:0] a);
    logic [31:0] exp;
    if (use_a) begin
      applyStimulus(0, 1, 0, jdoAddr(a, 1'b1));
      model_addr = a;
      model_err  = 1'b0;
      exp        = model_mem[a];
    end else begin
      applyStimulus(0, 0, 1, '0);
      exp        = model_mem[model_addr];
      model_addr = model_addr + 8'd1;
    end
    checkOutput("rd_busy1", monitor_ready, 0);
    tick();
    checkOutput("rd_busy2", monitor_ready, 0);
    checkOutput("rd_mon_old", MonDReg, model_mon);
    tick();
    checkOutput("rd_ready", monitor_ready, 1);
    checkOutput("rd_mondreg", MonDReg, exp);
    checkOutput("rd_err", monitor_error, model_err);
    model_mon = exp;
  endtask

  task automatic cpuWait();
    int n;
    n = 0;
    while (bus.ram_waitrequest !== 1'b0 && n < 32) begin
      tick();
      n++;
    end
    checkOutput("cpu_wait_timeout", bus.ram_waitrequest, 0);
  endtask

  task automatic cpuWrite(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                          input logic dbg, input logic also_rd);
    logic doit;
    bus.ram_address    = a;
    bus.ram_writedata  = d;
    bus.ram_byteenable = be;
    bus.debugaccess    = dbg;
    bus.ram_write      = 1'b1;
    bus.ram_read       = also_rd;
    cpuWait();
    tick();
    bus.ram_write = 1'b0;
    bus.ram_read  = 1'b0;
    doit = 1'b1;
`ifdef DEBUG_MON_WRITE_PROTECT_EN
    doit = dbg;
`endif
    if (doit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) model_mem[a][8*i +: 8] = d[8*i +: 8];
      end
    end
  endtask

  task automatic cpuRead(input logic [7:0] a);
    bus.ram_address = a;
    bus.ram_read    = 1'b1;
    cpuWait();
    tick();
    bus.ram_read = 1'b0;
    model_cpu_rd = model_mem[a];
    checkOutput("cpu_rd", bus.ram_readdata, model_cpu_rd);
    tick();
    checkOutput("cpu_rd_held", bus.ram_readdata, model_cpu_rd);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] exp;
    logic [7:0]  tgt;
    logic [31:0] old;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_mondreg", MonDReg, 0);
    checkOutput("rst_ready", monitor_ready, 1);
    checkOutput("rst_error", monitor_error, 0);
    checkOutput("rst_readdata", bus.ram_readdata, 0);
    checkOutput("rst_waitreq", bus.ram_waitrequest, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Fill the whole RAM through auto-incrementing JTAG writes (wraps back to 0)
    jtagAddr(8'h00);
    for (int i = 0; i < 256; i++) jtagWrite($urandom);

    // Write then read back at 0x10
    jtagAddr(8'h10);
    jtagWrite(32'hDEADBEEF);
    jtagRead(1'b1, 8'h10);

    // Address wrap 0xFF -> 0x00 on write, then read-increment
    jtagAddr(8'hFF);
    jtagWrite(32'h0000_0001);
    jtagRead(1'b0, 8'h00);
    jtagWrite(32'h0000_0077);
    jtagRead(1'b1, 8'hFF);
    jtagRead(1'b1, 8'h01);

    // Strobe while busy: dropped, error set, address advanced only by the accepted op
    exp        = model_mem[model_addr];
    model_addr = model_addr + 8'd1;
    applyStimulus(0, 0, 1, '0);
    applyStimulus(1, 0, 0, jdoData(32'h0BAD0BAD));
    model_err = 1'b1;
    checkOutput("drop_err_set", monitor_error, 1);
    checkOutput("drop_busy", monitor_ready, 0);
    tick();
    checkOutput("drop_mondreg", MonDReg, exp);
    checkOutput("drop_ready", monitor_ready, 1);
    model_mon = exp;
    jtagRead(1'b0, 8'h00);
    jtagAddr(8'h40);

    // Simultaneous strobes: b wins, no error; then a beats no_action
    applyStimulus(1, 1, 1, jdoData(32'h1234ABCD));
    model_mem[model_addr] = 32'h1234ABCD;
    model_addr            = model_addr + 8'd1;
    tick();
    checkOutput("prio_b_noerr", monitor_error, 0);
    applyStimulus(0, 1, 1, jdoAddr(8'h40, 1'b1));
    model_addr = 8'h40;
    tick();
    tick();
    checkOutput("prio_a_mondreg", MonDReg, model_mem[8'h40]);
    model_mon = model_mem[8'h40];
    jtagRead(1'b0, 8'h00);

    // CPU byte-masked write stalled behind a JTAG read
    cpuWrite(8'h20, 32'h0, 4'hF, 1'b1, 1'b0);
    applyStimulus(0, 1, 0, jdoAddr(8'h10, 1'b1));
    model_addr            = 8'h10;
    bus.ram_address       = 8'h20;
    bus.ram_writedata     = 32'h12345678;
    bus.ram_byteenable    = 4'b0011;
    bus.debugaccess       = 1'b1;
    bus.ram_write         = 1'b1;
    #1;
    checkOutput("stall_access", bus.ram_waitrequest, 1);
    tick();
    checkOutput("stall_capture", bus.ram_waitrequest, 1);
    tick();
    checkOutput("stall_released", bus.ram_waitrequest, 0);
    checkOutput("stall_mondreg", MonDReg, model_mem[8'h10]);
    model_mon = model_mem[8'h10];
    tick();
    bus.ram_write = 1'b0;
    model_mem[8'h20][15:0] = 16'h5678;
    cpuRead(8'h20);
    checkOutput("byte_merge", model_mem[8'h20], 32'h00005678);

    // Read+write together acts as a write; readdata keeps last CPU read
    cpuWrite(8'h21, 32'hCAFEF00D, 4'hF, 1'b1, 1'b1);
    checkOutput("rw_keeps_rdata", bus.ram_readdata, model_cpu_rd);
    cpuRead(8'h21);

    // debugaccess gating (model follows the build's macro)
    cpuWrite(8'h30, 32'hAAAA5555, 4'hF, 1'b0, 1'b0);
    cpuRead(8'h30);
    cpuWrite(8'h30, 32'h5555AAAA, 4'hF, 1'b1, 1'b0);
    cpuRead(8'h30);

    // Reset during a JTAG write in ACCESS: write lost, outputs back to reset values
    jtagRead(1'b1, 8'h50);
    tgt = model_addr;
    old = model_mem[tgt];
    applyStimulus(1, 0, 0, jdoData(~old));
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_ready", monitor_ready, 1);
    checkOutput("midrst_mondreg", MonDReg, 0);
    checkOutput("midrst_error", monitor_error, 0);
    @(negedge clk);
    reset_n    = 1'b1;
    model_addr = 8'd0;
    model_err  = 1'b0;
    model_mon  = 32'd0;
    tick();
    cpuRead(tgt);
    jtagRead(1'b0, 8'h00);

    // Randomized mix of JTAG and CPU traffic
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 4))
        0: cpuWrite(8'($urandom), $urandom, 4'($urandom), 1'($urandom), 1'b0);
        1: cpuRead(8'($urandom));
        2: jtagWrite($urandom);
        3: jtagRead(1'b1, 8'($urandom));
        default: jtagRead(1'b0, 8'h00);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
